// File: rtl/bin_to_bcd_display_if.sv
// Interface bundling the request/response signals of bin_to_bcd_display.
// The master drives start/value (the arithmetic datapath). The slave is the
// converter, which returns status and the three BCD digits for the
// char_7seg decoders.
interface bin_to_bcd_display_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [3:0]       bcd1;
    logic [3:0]       bcd10;
    logic [3:0]       bcd100;

    modport master (
        output start,
        output value,
        input  busy,
        input  done,
        input  overflow,
        input  bcd1,
        input  bcd10,
        input  bcd100
    );

    modport slave (
        input  start,
        input  value,
        output busy,
        output done,
        output overflow,
        output bcd1,
        output bcd10,
        output bcd100
    );
endinterface

// File: rtl/bin_to_bcd_display.sv
// bin_to_bcd_display: sequential binary-to-BCD converter (shift-and-add-3).
//
// A start in IDLE captures the unsigned operand. WIDTH adjust-and-shift
// iterations follow, one per clock. One final cycle then registers the three
// low BCD digits and pulses done. Operands above 999 saturate to 9,9,9 and
// raise overflow. Overflow holds until the next done.
//
// Optional feature: define BCD_LEADING_BLANK_EN to replace leading zero digits
// with 4'hF, which is the blank code of the display decoder. Only bcd100 and
// bcd10 can be blanked, and only on a done cycle. Reset values stay 0.
module bin_to_bcd_display #(
    parameter int WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    bin_to_bcd_display_if.slave   bus
);

    // The counter must hold the value WIDTH itself, not only WIDTH-1.
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             accept;
    logic             shift_en;
    logic             finish;

    logic [WIDTH-1:0] bin_q;
    logic [19:0]      scratch_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_pend_q;

    logic             busy_q;
    logic             done_q;
    logic             overflow_q;
    logic [3:0]       bcd1_q;
    logic [3:0]       bcd10_q;
    logic [3:0]       bcd100_q;

    logic [11:0]      digits_fmt;

    // Add 3 to every BCD digit that is 5 or more, so that the following
    // left shift carries correctly into the next decimal digit.
    function automatic logic [19:0] add3_digits(input logic [19:0] s);
        logic [19:0] r;
        logic [3:0]  d;
        r = s;
        for (int i = 0; i < 5; i++) begin
            d = s[4*i +: 4];
            if (d >= 4'd5) begin
                r[4*i +: 4] = d + 4'd3;
            end
        end
        return r;
    endfunction

    // Operands that do not fit in three digits display as 9,9,9.
    function automatic logic [11:0] saturate_digits(input logic [11:0] d,
                                                    input logic        ovf);
        return ovf ? 12'h999 : d;
    endfunction

    // Leading-zero suppression. The units digit is always shown.
    function automatic logic [11:0] blank_leading(input logic [11:0] d);
        logic [11:0] r;
        r = d;
`ifdef BCD_LEADING_BLANK_EN
        if (d[11:8] == 4'd0) begin
            r[11:8] = 4'hF;
            if (d[7:4] == 4'd0) begin
                r[7:4] = 4'hF;
            end
        end
`endif
        return r;
    endfunction

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and datapath step strobes. The cycle with cnt_q == 0
    // is the completion step, after the WIDTH shift iterations.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        shift_en   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    shift_en = 1'b1;
                end else begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Conversion datapath: operand capture, then adjust-and-shift of
    // {scratch, binary}. A start while busy is ignored because it is only
    // honoured in IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
        end else if (accept) begin
            bin_q      <= bus.value;
            scratch_q  <= '0;
            cnt_q      <= CNT_W'(WIDTH);
            ovf_pend_q <= (32'(bus.value) > 32'd999);
        end else if (shift_en) begin
            {scratch_q, bin_q} <= {add3_digits(scratch_q), bin_q} << 1;
            cnt_q              <= cnt_q - CNT_W'(1);
        end
    end

    // Units, tens and hundreds digits: saturation takes priority over blanking.
    assign digits_fmt = saturate_digits(blank_leading(scratch_q[11:0]), ovf_pend_q);

    // Output registers. Digits and overflow change only on completion.
    // busy covers exactly the shift iterations.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bcd1_q     <= 4'd0;
            bcd10_q    <= 4'd0;
            bcd100_q   <= 4'd0;
        end else begin
            busy_q <= shift_en;
            done_q <= finish;
            if (finish) begin
                overflow_q <= ovf_pend_q;
                bcd100_q   <= digits_fmt[11:8];
                bcd10_q    <= digits_fmt[7:4];
                bcd1_q     <= digits_fmt[3:0];
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.bcd1     = bcd1_q;
    assign bus.bcd10    = bcd10_q;
    assign bus.bcd100   = bcd100_q;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Scoreboard testbench for bin_to_bcd_display.
// Stimulus pushes the hand-computed expected digits, overflow flag and done
// cycle. A monitor compares them on every done pulse.
module tb_bin_to_bcd_display;

    localparam int W = 10;
`ifdef BCD_LEADING_BLANK_EN
    localparam int BL = 15;
`else
    localparam int BL = 0;
`endif

    typedef struct {
        int d100;
        int d10;
        int d1;
        int ovf;
        int cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_total;
    int   n_pass;
    int   busy_run;
    exp_t sb[$];

    bin_to_bcd_display_if #(.WIDTH(W)) bus ();

    bin_to_bcd_display #(.WIDTH(W)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Monitor: compare every done pulse against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (bus.busy) busy_run++;
            if (bus.done) begin
                check("expected_result_queued", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("bcd100", int'(bus.bcd100), e.d100);
                    check("bcd10", int'(bus.bcd10), e.d10);
                    check("bcd1", int'(bus.bcd1), e.d1);
                    check("overflow", int'(bus.overflow), e.ovf);
                    check("done_cycle", cyc, e.cyc);
                    check("busy_cycles", busy_run, W);
                    check("busy_low_on_done", int'(bus.busy), 0);
                end
                busy_run = 0;
            end
        end
    end

    task automatic do_start(input int v, input bit push,
                            input int d100, input int d10, input int d1, input int ovf);
        @(negedge clk);
        bus.value = v[W-1:0];
        bus.start = 1'b1;
        if (push) sb.push_back('{d100, d10, d1, ovf, cyc + 1 + W + 1});
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * W && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bcd1"}, int'(bus.bcd1), 0);
        check({tag, "_bcd10"}, int'(bus.bcd10), 0);
        check({tag, "_bcd100"}, int'(bus.bcd100), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_overflow"}, int'(bus.overflow), 0);
    endtask

    initial begin
        bit seen;
        cyc       = 0;
        n_total   = 0;
        n_pass    = 0;
        busy_run  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.value = '0;

        // Reset held, then released
        repeat (3) @(negedge clk);
        check_zero("in_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("after_reset");

        // Basic conversions
        do_start(637, 1, 6, 3, 7, 0);
        drain();
        do_start(0, 1, BL, BL, 0, 0);
        drain();
        do_start(999, 1, 9, 9, 9, 0);
        drain();

        // Overflow saturation, then recovery
        do_start(1000, 1, 9, 9, 9, 1);
        drain();
        do_start(1023, 1, 9, 9, 9, 1);
        drain();
        do_start(42, 1, BL, 4, 2, 0);
        drain();
        repeat (5) @(negedge clk);
        check("hold_bcd10", int'(bus.bcd10), 4);
        check("hold_bcd1", int'(bus.bcd1), 2);

        // Asynchronous reset between edges clears the held outputs
        do_start(637, 1, 6, 3, 7, 0);
        drain();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Start while busy is ignored; start in the done cycle is accepted
        do_start(123, 1, 1, 2, 3, 0);
        repeat (2) @(posedge clk);
        do_start(456, 0, 0, 0, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 4 * W && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check("done_seen_for_123", int'(seen), 1);
        bus.value = 10'd456;
        bus.start = 1'b1;
        sb.push_back('{4, 5, 6, 0, cyc + 1 + W + 1});
        @(posedge clk);
        #1 bus.start = 1'b0;
        drain();

        // Reset in the middle of a conversion: no done, outputs return to 0
        do_start(500, 0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("midop_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * W) @(negedge clk);
        check_zero("no_done_after_abort");
        do_start(8, 1, BL, BL, 8, 0);
        drain();

`ifdef BCD_LEADING_BLANK_EN
        do_start(7, 1, 15, 15, 7, 0);
        drain();
        do_start(40, 1, 15, 4, 0, 0);
        drain();
        do_start(305, 1, 3, 0, 5, 0);
        drain();
        do_start(1000, 1, 9, 9, 9, 1);
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
